// File: rtl/execute_stage.sv
//==============================================================================
// Module   : execute_stage
// Purpose  : ID/EX pipeline register, operand forwarding, 16-bit ALU and a
//            multi-cycle shift-add multiplier that stalls the front end.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module execute_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        IRegWrite,
  input  logic        IMemWrite,
  input  logic        IMemRead,
  input  logic [1:0]  IRegStore,
  input  logic [15:0] IPCP2,
  input  logic [15:0] IRs1Val,
  input  logic [15:0] IRs2Val,
  input  logic [15:0] IImm,
  input  logic [2:0]  IRs1,
  input  logic [2:0]  IRs2,
  input  logic [2:0]  IRd,
  input  logic [3:0]  IALUOp,
  input  logic        IALUSrc,
  input  logic [2:0]  MemFwdRd,
  input  logic        MemFwdWrite,
  input  logic [15:0] MemFwdVal,
  input  logic [2:0]  WbFwdRd,
  input  logic        WbFwdWrite,
  input  logic [15:0] WbFwdVal,
  output logic        ORegWrite,
  output logic        OMemWrite,
  output logic        OMemRead,
  output logic [1:0]  ORegStore,
  output logic [15:0] OPCP2,
  output logic [2:0]  ORd,
  output logic [15:0] OALUResult,
  output logic [15:0] O3rdArg,
  output logic        busy
);

  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  reg_store;
    logic [15:0] pcp2;
    logic [15:0] rs1_val;
    logic [15:0] rs2_val;
    logic [15:0] imm;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [2:0]  rd;
    logic [3:0]  alu_op;
    logic        alu_src;
  } idex_t;

  idex_t       idex;
  idex_t       idex_in;
  mul_state_t  state;
  mul_state_t  state_next;
  logic [15:0] fwd_a;
  logic [15:0] fwd_b;
  logic [15:0] op_b;
  logic [3:0]  shamt;
  logic [15:0] alu_result;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [15:0] mul_acc;
  logic [3:0]  mul_cnt;

  assign idex_in = '{
    reg_write: IRegWrite, mem_write: IMemWrite, mem_read: IMemRead,
    reg_store: IRegStore, pcp2: IPCP2, rs1_val: IRs1Val, rs2_val: IRs2Val,
    imm: IImm, rs1: IRs1, rs2: IRs2, rd: IRd, alu_op: IALUOp,
    alu_src: IALUSrc
  };

  // While busy the instruction stays put; flush always wins with a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idex <= '0;
    end else if (flush) begin
      idex <= '0;
    end else if (!busy) begin
      idex <= idex_in;
    end
  end

  // r0 is hard-wired zero and must never pick up a forwarded value.
  always_comb begin
    fwd_a = idex.rs1_val;
    if (idex.rs1 == 3'd0) begin
      fwd_a = '0;
    end else if (MemFwdWrite && (MemFwdRd == idex.rs1)) begin
      fwd_a = MemFwdVal;
    end else if (WbFwdWrite && (WbFwdRd == idex.rs1)) begin
      fwd_a = WbFwdVal;
    end
  end

  always_comb begin
    fwd_b = idex.rs2_val;
    if (idex.rs2 == 3'd0) begin
      fwd_b = '0;
    end else if (MemFwdWrite && (MemFwdRd == idex.rs2)) begin
      fwd_b = MemFwdVal;
    end else if (WbFwdWrite && (WbFwdRd == idex.rs2)) begin
      fwd_b = WbFwdVal;
    end
  end

  assign op_b  = idex.alu_src ? idex.imm : fwd_b;
  assign shamt = op_b[3:0];

  always_comb begin
    alu_result = op_b;
    case (idex.alu_op)
      4'd0:    alu_result = fwd_a + op_b;
      4'd1:    alu_result = fwd_a - op_b;
      4'd2:    alu_result = fwd_a & op_b;
      4'd3:    alu_result = fwd_a | op_b;
      4'd4:    alu_result = fwd_a ^ op_b;
      4'd5:    alu_result = fwd_a << shamt;
      4'd6:    alu_result = fwd_a >> shamt;
      4'd7:    alu_result = $signed(fwd_a) >>> shamt;
      4'd8:    alu_result = {15'd0, ($signed(fwd_a) < $signed(op_b))};
      4'd9:    alu_result = {15'd0, (fwd_a < op_b)};
      OP_MUL:  alu_result = mul_acc;
      default: alu_result = op_b;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (idex.alu_op == OP_MUL) state_next = ST_RUN;
      ST_RUN:  if (mul_cnt == 4'd15) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (flush) begin
      state_next = ST_IDLE;
    end
  end

  // Operands are captured once, so later forwarding changes cannot disturb the product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_a   <= '0;
      mul_b   <= '0;
      mul_acc <= '0;
      mul_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (idex.alu_op == OP_MUL) begin
            mul_a   <= fwd_a;
            mul_b   <= op_b;
            mul_acc <= '0;
            mul_cnt <= '0;
          end
        end
        ST_RUN: begin
          mul_acc <= mul_acc + (mul_b[0] ? mul_a : 16'd0);
          mul_a   <= {mul_a[14:0], 1'b0};
          mul_b   <= {1'b0, mul_b[15:1]};
          mul_cnt <= mul_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy = ((state == ST_IDLE) && (idex.alu_op == OP_MUL)) || (state == ST_RUN);

  assign ORegWrite  = idex.reg_write & ~busy;
  assign OMemWrite  = idex.mem_write & ~busy;
  assign OMemRead   = idex.mem_read & ~busy;
  assign ORegStore  = busy ? 2'b00 : idex.reg_store;
  assign OPCP2      = idex.pcp2;
  assign ORd        = idex.rd;
  assign OALUResult = alu_result;
  assign O3rdArg    = fwd_b;

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
//==============================================================================
// Module   : tb_execute_stage
// Purpose  : Directed self-checking bench for execute_stage.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        IRegWrite = 1'b0, IMemWrite = 1'b0, IMemRead = 1'b0;
  logic [1:0]  IRegStore = '0;
  logic [15:0] IPCP2 = '0, IRs1Val = '0, IRs2Val = '0, IImm = '0;
  logic [2:0]  IRs1 = '0, IRs2 = '0, IRd = '0;
  logic [3:0]  IALUOp = '0;
  logic        IALUSrc = 1'b0;
  logic [2:0]  MemFwdRd = '0, WbFwdRd = '0;
  logic        MemFwdWrite = 1'b0, WbFwdWrite = 1'b0;
  logic [15:0] MemFwdVal = '0, WbFwdVal = '0;
  logic        ORegWrite, OMemWrite, OMemRead;
  logic [1:0]  ORegStore;
  logic [15:0] OPCP2, OALUResult, O3rdArg;
  logic [2:0]  ORd;
  logic        busy;

  int tests = 0;
  int fails = 0;

  execute_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .IRegWrite(IRegWrite), .IMemWrite(IMemWrite), .IMemRead(IMemRead),
    .IRegStore(IRegStore), .IPCP2(IPCP2), .IRs1Val(IRs1Val), .IRs2Val(IRs2Val),
    .IImm(IImm), .IRs1(IRs1), .IRs2(IRs2), .IRd(IRd), .IALUOp(IALUOp),
    .IALUSrc(IALUSrc),
    .MemFwdRd(MemFwdRd), .MemFwdWrite(MemFwdWrite), .MemFwdVal(MemFwdVal),
    .WbFwdRd(WbFwdRd), .WbFwdWrite(WbFwdWrite), .WbFwdVal(WbFwdVal),
    .ORegWrite(ORegWrite), .OMemWrite(OMemWrite), .OMemRead(OMemRead),
    .ORegStore(ORegStore), .OPCP2(OPCP2), .ORd(ORd),
    .OALUResult(OALUResult), .O3rdArg(O3rdArg), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd;
    MemFwdRd = '0; MemFwdWrite = 1'b0; MemFwdVal = '0;
    WbFwdRd  = '0; WbFwdWrite  = 1'b0; WbFwdVal  = '0;
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                           input logic [2:0] rd, input logic [15:0] v1, input logic [15:0] v2,
                           input logic [15:0] imm, input logic src, input logic rw,
                           input logic mw, input logic mr, input logic [1:0] rstore,
                           input logic [15:0] pc);
    IALUOp = op; IRs1 = rs1; IRs2 = rs2; IRd = rd; IRs1Val = v1; IRs2Val = v2;
    IImm = imm; IALUSrc = src; IRegWrite = rw; IMemWrite = mw; IMemRead = mr;
    IRegStore = rstore; IPCP2 = pc;
  endtask

  task automatic test_reset;
    #1;
    tests++;
    if ({ORegWrite, OMemWrite, OMemRead, ORegStore, OPCP2, ORd, OALUResult, O3rdArg, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: res=%h st=%h rd=%h busy=%b, expected all zero",
               OALUResult, O3rdArg, ORd, busy);
    end
    step; step;
    reset = 1'b1;
  endtask

  task automatic test_add_forward;
    clear_fwd();
    set_instr(4'd0, 3'd3, 3'd0, 3'd1, 16'h9999, 16'h0000, 16'h0010, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 16'h0102);
    MemFwdRd = 3'd3; MemFwdWrite = 1'b1; MemFwdVal = 16'h1234;
    step;
    tests++;
    if (OALUResult !== 16'h1244) begin
      fails++; $display("FAIL add_mem_fwd: got %h, expected 1244", OALUResult);
    end
    tests++;
    if ({ORegWrite, OMemWrite, OMemRead, ORegStore, ORd, OPCP2} !== {1'b1, 1'b0, 1'b0, 2'b01, 3'd1, 16'h0102}) begin
      fails++;
      $display("FAIL add_passthru: rw=%b mw=%b mr=%b rs=%b rd=%0d pc=%h, expected 1 0 0 01 1 0102",
               ORegWrite, OMemWrite, OMemRead, ORegStore, ORd, OPCP2);
    end
  endtask

  task automatic test_forward_priority;
    set_instr(4'd0, 3'd0, 3'd2, 3'd4, 16'h5555, 16'h0011, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0000);
    MemFwdRd = 3'd2; MemFwdWrite = 1'b1; MemFwdVal = 16'h00AA;
    WbFwdRd  = 3'd2; WbFwdWrite  = 1'b1; WbFwdVal  = 16'h00BB;
    step;
    tests++;
    if (O3rdArg !== 16'h00AA || OALUResult !== 16'h00AA) begin
      fails++; $display("FAIL fwd_mem_over_wb: store=%h res=%h, expected 00aa 00aa", O3rdArg, OALUResult);
    end
    MemFwdRd = 3'd0; MemFwdVal = 16'h7777;
    #1;
    tests++;
    if (O3rdArg !== 16'h00BB || OALUResult !== 16'h00BB) begin
      fails++; $display("FAIL fwd_r0_wb: store=%h res=%h, expected 00bb 00bb", O3rdArg, OALUResult);
    end
    WbFwdWrite = 1'b0;
    #1;
    tests++;
    if (O3rdArg !== 16'h0011 || OALUResult !== 16'h0011) begin
      fails++; $display("FAIL fwd_none: store=%h res=%h, expected 0011 0011", O3rdArg, OALUResult);
    end
  endtask

  task automatic test_alu_ops;
    logic [3:0]  op_t  [11];
    logic [15:0] a_t   [11];
    logic [15:0] b_t   [11];
    logic [15:0] exp_t [11];
    op_t  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12};
    a_t   = '{16'hFFFF, 16'h0001, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'h0001, 16'h8000,
              16'h8000, 16'hFFFF, 16'hFFFF, 16'h1111};
    b_t   = '{16'h0002, 16'h0002, 16'h3C3C, 16'h3C3C, 16'h3C3C, 16'h0014, 16'h0004,
              16'h0004, 16'h0001, 16'h0001, 16'hBEEF};
    exp_t = '{16'h0001, 16'hFFFF, 16'h3030, 16'hFCFC, 16'hCCCC, 16'h0010, 16'h0800,
              16'hF800, 16'h0001, 16'h0000, 16'hBEEF};
    clear_fwd();
    for (int i = 0; i < 11; i++) begin
      set_instr(op_t[i], 3'd1, 3'd2, 3'd5, a_t[i], b_t[i], 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0000);
      step;
      tests++;
      if (OALUResult !== exp_t[i]) begin
        fails++;
        $display("FAIL alu[%0d] op=%0d a=%h b=%h: got %h, expected %h",
                 i, op_t[i], a_t[i], b_t[i], OALUResult, exp_t[i]);
      end
    end
  endtask

  task automatic test_mul;
    int busy_cycles;
    int bad_ctrl;
    clear_fwd();
    set_instr(4'd10, 3'd4, 3'd5, 3'd6, 16'h0123, 16'h0045, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 16'h0200);
    step;
    busy_cycles = 0;
    bad_ctrl = 0;
    while (busy && busy_cycles < 40) begin
      busy_cycles++;
      if (ORegWrite || OMemWrite || OMemRead || ORegStore != 2'b00) bad_ctrl++;
      if (busy_cycles == 2) begin
        MemFwdRd = 3'd4; MemFwdWrite = 1'b1; MemFwdVal = 16'hFFFF;
        WbFwdRd  = 3'd5; WbFwdWrite  = 1'b1; WbFwdVal  = 16'h7FFF;
      end
      step;
    end
    tests++;
    if (busy_cycles != 17) begin
      fails++; $display("FAIL mul_busy_len: got %0d cycles, expected 17", busy_cycles);
    end
    tests++;
    if (bad_ctrl != 0) begin
      fails++; $display("FAIL mul_ctrl_forced: %0d busy cycles with controls set, expected 0", bad_ctrl);
    end
    tests++;
    if (OALUResult !== 16'h4E6F) begin
      fails++; $display("FAIL mul_result: got %h, expected 4e6f", OALUResult);
    end
    tests++;
    if ({ORegWrite, OMemRead, ORegStore, ORd} !== {1'b1, 1'b1, 2'b10, 3'd6}) begin
      fails++;
      $display("FAIL mul_done_ctrl: rw=%b mr=%b rs=%b rd=%0d, expected 1 1 10 6",
               ORegWrite, OMemRead, ORegStore, ORd);
    end
    clear_fwd();
    set_instr(4'd0, 3'd1, 3'd0, 3'd2, 16'h0005, 16'h0000, 16'h0003, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0000);
    step;
    tests++;
    if (busy !== 1'b0 || OALUResult !== 16'h0008) begin
      fails++; $display("FAIL mul_followup: busy=%b res=%h, expected 0 0008", busy, OALUResult);
    end
  endtask

  task automatic test_flush_mul;
    clear_fwd();
    set_instr(4'd10, 3'd1, 3'd2, 3'd3, 16'h0003, 16'h0004, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 16'h0300);
    step;
    for (int i = 0; i < 6; i++) step;
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL flush_pre_busy: busy=%b, expected 1", busy);
    end
    flush = 1'b1;
    step;
    flush = 1'b0;
    set_instr(4'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    tests++;
    if ({busy, ORegWrite, OMemWrite, OMemRead, ORegStore, ORd, OPCP2, OALUResult} !== '0) begin
      fails++;
      $display("FAIL flush_bubble: busy=%b rw=%b mw=%b mr=%b rs=%b rd=%0d pc=%h res=%h, expected all zero",
               busy, ORegWrite, OMemWrite, OMemRead, ORegStore, ORd, OPCP2, OALUResult);
    end
    step;
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL flush_stays_idle: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_run;
    clear_fwd();
    set_instr(4'd10, 3'd1, 3'd2, 3'd3, 16'h0021, 16'h0013, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 16'h0400);
    step;
    for (int i = 0; i < 3; i++) step;
    #3;
    reset = 1'b0;
    #1;
    tests++;
    if ({ORegWrite, OMemWrite, OMemRead, ORegStore, OPCP2, ORd, OALUResult, O3rdArg, busy} !== '0) begin
      fails++;
      $display("FAIL async_reset: res=%h st=%h pc=%h rd=%0d busy=%b, expected all zero",
               OALUResult, O3rdArg, OPCP2, ORd, busy);
    end
    step; step;
    set_instr(4'd0, 3'd1, 3'd2, 3'd3, 16'h0100, 16'h0023, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0010);
    reset = 1'b1;
    step;
    tests++;
    if (busy !== 1'b0 || OALUResult !== 16'h0123 || ORegWrite !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_add: busy=%b res=%h rw=%b, expected 0 0123 1", busy, OALUResult, ORegWrite);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    clear_fwd();
    set_instr(4'd10, 3'd1, 3'd2, 3'd3, 16'h0007, 16'h0009, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0000);
    step;
    n = 0;
    while (busy && n < 40) begin n++; step; end
    tests++;
    if (n != 17 || OALUResult !== 16'h003F) begin
      fails++; $display("FAIL b2b_mul1: busy=%0d res=%h, expected 17 003f", n, OALUResult);
    end
    set_instr(4'd10, 3'd1, 3'd0, 3'd3, 16'h0101, 16'h0000, 16'h0101, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0000);
    step;
    n = 0;
    while (busy && n < 40) begin n++; step; end
    tests++;
    if (n != 17 || OALUResult !== 16'h0201) begin
      fails++; $display("FAIL b2b_mul2: busy=%0d res=%h, expected 17 0201", n, OALUResult);
    end
  endtask

  initial begin
    test_reset();
    test_add_forward();
    test_forward_priority();
    test_alu_ops();
    test_mul();
    test_flush_mul();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
